// File: rtl/key_press_classifier.sv
// key_press_classifier: turns a debounced active-low button level into
// short / long / repeat / double-click one-cycle event pulses.
module key_press_classifier #(
  parameter int unsigned LONG_CYC = 100_000_000,
  parameter int unsigned DBL_CYC  = 30_000_000,
  parameter int unsigned RPT_CYC  = 20_000_000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    WAIT_REL  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_T  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(RPT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_prev_q, btn_prev_d;
  logic             armed_q, armed_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             dbl_q, dbl_d;
  logic             busy_q, busy_d;
  logic             press_edge;

  // A level held low through reset is not a press: edges only count
  // once the button has been seen released after reset.
  assign press_edge = btn_prev_q & ~btn_n & armed_q;

  // Next-state, counter and pulse decode; each pulse is a registered
  // result of the edge that decides it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    btn_prev_d = btn_n;
    armed_d    = armed_q | btn_n;
    short_d    = 1'b0;
    long_d     = 1'b0;
    rpt_d      = 1'b0;
    dbl_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press_edge) state_d = PRESS1;
      end
      PRESS1: begin
        if (cnt_q == LONG_T) begin
          long_d  = 1'b1;
          state_d = LONG_HOLD;
          cnt_d   = '0;
        end else if (btn_n) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end
      end
      LONG_HOLD: begin
        if (btn_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RPT_T) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end
      end
      WAIT2: begin
        if (press_edge) begin
          dbl_d   = 1'b1;
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == DBL_T) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_REL: begin
        cnt_d = '0;
        if (btn_n) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter, edge history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      btn_prev_q <= 1'b1;
      armed_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
      dbl_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
      short_q    <= short_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
      dbl_q      <= dbl_d;
      busy_q     <= busy_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rpt_q;
  assign double_pulse = dbl_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier: directed gesture scenarios with
// hand-computed pulse timing for the key press classifier.
module tb_key_press_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic short_pulse, long_pulse, repeat_pulse;
  logic double_pulse, busy;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int multi = 0;
  int n_short, n_long, n_rpt, n_dbl;
  int t_short, t_long, t_rpt, t_rpt_last, t_dbl;

  key_press_classifier #(
    .LONG_CYC(20),
    .DBL_CYC (8),
    .RPT_CYC (5),
    .CNT_W   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .double_pulse(double_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts, first/last cycle, and one-hot violations.
  always @(negedge clk) begin
    if (short_pulse) begin
      n_short++;
      if (t_short < 0) t_short = cyc;
    end
    if (long_pulse) begin
      n_long++;
      if (t_long < 0) t_long = cyc;
    end
    if (repeat_pulse) begin
      n_rpt++;
      if (t_rpt < 0) t_rpt = cyc;
      t_rpt_last = cyc;
    end
    if (double_pulse) begin
      n_dbl++;
      if (t_dbl < 0) t_dbl = cyc;
    end
    if (int'(short_pulse) + int'(long_pulse) +
        int'(repeat_pulse) + int'(double_pulse) > 1)
      multi++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_rpt = 0; n_dbl = 0;
    t_short = -1; t_long = -1; t_rpt = -1;
    t_rpt_last = -1; t_dbl = -1;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    rst = 1'b1;
    btn_n = 1'b1;
    tick(3);
    o = {short_pulse, long_pulse, repeat_pulse,
         double_pulse, busy};
    total++;
    if (o !== 5'b0)
      $display("FAIL reset_outs got=%b exp=00000", o);
    else passed++;
    rst = 1'b0;
    clear_counts();
    tick(4);
    total++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got=%b exp=0", busy);
    else passed++;
    total++;
    if (n_short + n_long + n_rpt + n_dbl != 0)
      $display("FAIL reset_pulses got=%0d exp=0",
               n_short + n_long + n_rpt + n_dbl);
    else passed++;
  endtask

  task automatic test_short();
    int r;
    clear_counts();
    btn_n = 1'b0;
    tick(5);
    btn_n = 1'b1;
    r = cyc;
    tick(30);
    total++;
    if (n_short != 1)
      $display("FAIL short_cnt got=%0d exp=1", n_short);
    else passed++;
    total++;
    if (t_short != r + 9)
      $display("FAIL short_time got=%0d exp=%0d",
               t_short, r + 9);
    else passed++;
    total++;
    if (n_long + n_rpt + n_dbl != 0)
      $display("FAIL short_others got=%0d exp=0",
               n_long + n_rpt + n_dbl);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL short_busy got=%b exp=0", busy);
    else passed++;
  endtask

  task automatic test_long();
    int p;
    clear_counts();
    btn_n = 1'b0;
    p = cyc;
    tick(32);
    btn_n = 1'b1;
    tick(15);
    total++;
    if (n_long != 1)
      $display("FAIL long_cnt got=%0d exp=1", n_long);
    else passed++;
    total++;
    if (t_long != p + 21)
      $display("FAIL long_time got=%0d exp=%0d",
               t_long, p + 21);
    else passed++;
    total++;
    if (n_rpt != 2)
      $display("FAIL rpt_cnt got=%0d exp=2", n_rpt);
    else passed++;
    total++;
    if (t_rpt != p + 26)
      $display("FAIL rpt_first got=%0d exp=%0d",
               t_rpt, p + 26);
    else passed++;
    total++;
    if (t_rpt_last != p + 31)
      $display("FAIL rpt_last got=%0d exp=%0d",
               t_rpt_last, p + 31);
    else passed++;
    total++;
    if (n_short + n_dbl != 0)
      $display("FAIL long_others got=%0d exp=0",
               n_short + n_dbl);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL long_busy got=%b exp=0", busy);
    else passed++;
  endtask

  task automatic test_double();
    int p2;
    clear_counts();
    btn_n = 1'b0;
    tick(3);
    btn_n = 1'b1;
    tick(4);
    btn_n = 1'b0;
    p2 = cyc;
    tick(50);
    total++;
    if (busy !== 1'b1)
      $display("FAIL dbl_busy_held got=%b exp=1", busy);
    else passed++;
    btn_n = 1'b1;
    tick(1);
    total++;
    if (busy !== 1'b0)
      $display("FAIL dbl_busy_drop got=%b exp=0", busy);
    else passed++;
    tick(20);
    total++;
    if (n_dbl != 1)
      $display("FAIL dbl_cnt got=%0d exp=1", n_dbl);
    else passed++;
    total++;
    if (t_dbl != p2 + 1)
      $display("FAIL dbl_time got=%0d exp=%0d",
               t_dbl, p2 + 1);
    else passed++;
    total++;
    if (n_short + n_long + n_rpt != 0)
      $display("FAIL dbl_others got=%0d exp=0",
               n_short + n_long + n_rpt);
    else passed++;
  endtask

  task automatic test_dbl_edge();
    int p2;
    clear_counts();
    btn_n = 1'b0;
    tick(2);
    btn_n = 1'b1;
    tick(8);
    btn_n = 1'b0;
    p2 = cyc;
    tick(3);
    btn_n = 1'b1;
    tick(20);
    total++;
    if (n_dbl != 1)
      $display("FAIL edge_dbl_cnt got=%0d exp=1", n_dbl);
    else passed++;
    total++;
    if (t_dbl != p2 + 1)
      $display("FAIL edge_dbl_time got=%0d exp=%0d",
               t_dbl, p2 + 1);
    else passed++;
    total++;
    if (n_short != 0)
      $display("FAIL edge_short got=%0d exp=0", n_short);
    else passed++;
  endtask

  task automatic test_rst_hold();
    int p;
    logic [4:0] o;
    clear_counts();
    btn_n = 1'b0;
    p = cyc;
    tick(26);
    total++;
    if (repeat_pulse !== 1'b1)
      $display("FAIL hold_rpt_pre got=%b exp=1",
               repeat_pulse);
    else passed++;
    rst = 1'b1;
    #1;
    o = {short_pulse, long_pulse, repeat_pulse,
         double_pulse, busy};
    total++;
    if (o !== 5'b0)
      $display("FAIL hold_rst_outs got=%b exp=00000", o);
    else passed++;
    tick(2);
    rst = 1'b0;
    clear_counts();
    tick(40);
    total++;
    if (n_short + n_long + n_rpt + n_dbl != 0)
      $display("FAIL hold_after_rst got=%0d exp=0",
               n_short + n_long + n_rpt + n_dbl);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL hold_busy got=%b exp=0", busy);
    else passed++;
    btn_n = 1'b1;
    tick(15);
    total++;
    if (n_short + n_long + n_rpt + n_dbl != 0)
      $display("FAIL hold_release got=%0d exp=0",
               n_short + n_long + n_rpt + n_dbl);
    else passed++;
    btn_n = 1'b0;
    p = cyc;
    tick(25);
    btn_n = 1'b1;
    tick(15);
    total++;
    if (n_long != 1 || t_long != p + 21)
      $display("FAIL fresh_long got=%0d@%0d exp=1@%0d",
               n_long, t_long, p + 21);
    else passed++;
    total++;
    if (n_rpt + n_short + n_dbl != 0)
      $display("FAIL fresh_others got=%0d exp=0",
               n_rpt + n_short + n_dbl);
    else passed++;
  endtask

  task automatic test_min_press();
    int r;
    clear_counts();
    btn_n = 1'b0;
    tick(1);
    btn_n = 1'b1;
    r = cyc;
    tick(20);
    total++;
    if (n_short != 1 || t_short != r + 9)
      $display("FAIL min_short got=%0d@%0d exp=1@%0d",
               n_short, t_short, r + 9);
    else passed++;
    total++;
    if (n_long + n_rpt + n_dbl != 0)
      $display("FAIL min_others got=%0d exp=0",
               n_long + n_rpt + n_dbl);
    else passed++;
  endtask

  task automatic test_onehot();
    total++;
    if (multi != 0)
      $display("FAIL onehot got=%0d exp=0", multi);
    else passed++;
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_short();
    test_long();
    test_double();
    test_dbl_edge();
    test_rst_hold();
    test_min_press();
    test_onehot();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
